// File: rtl/register.sv
// register: WIDTH-bit storage element with a load enable and an asynchronous
// active-high clear. q is driven straight from the storage flops, so there is
// no combinational path from data or en to the output.
module register #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next state: capture data when enabled, otherwise recirculate the held value.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = data;
        end
    end

    // Storage flops: reset forces RESET_VALUE immediately and takes priority over a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_register.sv
// tb_register: directed checks of the register block with two instances, one
// using the default all-zero reset value and one using 4'b1001.
module tb_register;

    localparam int WIDTH = 4;
    localparam logic [WIDTH-1:0] RV_A = 4'b0000;
    localparam logic [WIDTH-1:0] RV_B = 4'b1001;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data;
    logic             en;
    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;

    int checks = 0;
    int errors = 0;

    register #(.WIDTH(WIDTH)) dut_a (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .en    (en),
        .q     (q_a)
    );

    register #(.WIDTH(WIDTH), .RESET_VALUE(RV_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .en    (en),
        .q     (q_b)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] follow_vals [3];
    logic [WIDTH-1:0] prev;

    initial begin
        follow_vals[0] = 4'b0001;
        follow_vals[1] = 4'b0010;
        follow_vals[2] = 4'b0011;

        reset = 1'b0;
        en    = 1'b0;
        data  = 4'b0000;

        // Asynchronous reset before the first clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_a", q_a, RV_A);
        check("rst_async_b", q_b, RV_B);
        tick();
        check("rst_hold_a", q_a, RV_A);
        check("rst_hold_b", q_b, RV_B);

        // Release reset, keep en low: data must not reach q.
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        data  = 4'b1010;
        tick();
        check("hold_dis_a", q_a, RV_A);
        check("hold_dis_b", q_b, RV_B);

        // Load: unchanged before the edge, new value after.
        @(negedge clk);
        en   = 1'b1;
        data = 4'b1100;
        #1;
        check("load_pre_a", q_a, RV_A);
        check("load_pre_b", q_b, RV_B);
        tick();
        check("load_a", q_a, 4'b1100);
        check("load_b", q_b, 4'b1100);

        // Follow with en held high.
        @(negedge clk);
        data = 4'b0110;
        tick();
        check("follow_0110", q_a, 4'b0110);
        prev = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data = follow_vals[i];
            #1;
            check("follow_pre", q_a, prev);
            tick();
            check("follow_post", q_a, follow_vals[i]);
            check("follow_post_b", q_b, follow_vals[i]);
            prev = follow_vals[i];
        end

        // Reload 0110, then hold with en low across several edges.
        @(negedge clk);
        data = 4'b0110;
        tick();
        check("reload", q_a, 4'b0110);
        @(negedge clk);
        en   = 1'b0;
        data = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_load", q_a, 4'b0110);
            check("hold_load_b", q_b, 4'b0110);
        end

        // Asynchronous reset mid-operation between edges.
        @(negedge clk);
        en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_a", q_a, RV_A);
        check("midrst_b", q_b, RV_B);
        data = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_wins_a", q_a, RV_A);
            check("rst_wins_b", q_b, RV_B);
        end

        // First edge after release loads normally.
        @(negedge clk);
        reset = 1'b0;
        data  = 4'b0101;
        #1;
        check("rel_pre_b", q_b, RV_B);
        tick();
        check("rel_load_a", q_a, 4'b0101);
        check("rel_load_b", q_b, 4'b0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register.md
Name: register

Overview:
- Parameterised WIDTH-bit storage register with a load enable and an asynchronous clear.
- General-purpose datapath/state-holding element used wherever a value must be captured on command and held indefinitely.
- Single clock domain, no handshake. Output is driven directly from the storage flops.

Parameters:
- WIDTH, 4, bit width of data and q; legal range is 1 or more.
- RESET_VALUE, {WIDTH{1'b0}} (all zeros), value loaded into q while reset is asserted.

Ports:
- clk  input  1  rising-edge clock; all non-reset state changes occur on this edge.
- reset  input  1  one clock; reset is asynchronous and active-high.
- data  input  WIDTH  value to capture.
- en  input  1  load enable, active-high, sampled on the rising edge of clk.
- q  output  WIDTH  registered (stored) value.

Behaviour:
- Reset assertion:
  - When reset rises, q becomes RESET_VALUE immediately, without waiting for a clk edge.
  - q holds RESET_VALUE for as long as reset stays high, regardless of clk, en or data.
- Reset deassertion:
  - The first rising clk edge with reset low may load normally.
  - No extra recovery cycle is inserted.
- Load:
  - On a rising clk edge with reset=0 and en=1, q takes the value of data sampled at that edge.
  - Latency is 1 clock: new data is visible on q after that edge, not combinationally.
- Hold:
  - On a rising clk edge with reset=0 and en=0, q keeps its previous value.
  - Changes on data while en=0 never reach q.
- Continuous enable:
  - With en held at 1, q follows data with one-cycle delay on every edge.
  - Back-to-back loads are allowed with no bubble.
- Simultaneous events:
  - If reset is high at a clk edge where en=1, reset wins and q=RESET_VALUE.
  - Reset asserted mid-operation discards any stored value.
- Output path: q has no combinational path from data or en. The only path into q is through the flops, plus the asynchronous reset path.
- Power-up: q is undefined until the first reset. Benches must apply reset before checking q.
- X-handling: an X on en at an edge (with reset low) may corrupt q. This is a protocol violation and has no defined result.
- Width: data is captured in full with no truncation or extension; q has exactly WIDTH bits.

Test Plan (WIDTH=4, clk period 10 ns):
- Reset: reset=1, en=0, data=0000 for 10 ns -> q=0000 immediately after reset rises, before any clk edge. Repeat with RESET_VALUE=1001 -> q=1001.
- Hold while disabled: release reset (reset=0), then en=0, data=1010 for one cycle -> q stays 0000.
- Load: en=1, data=1100, one rising edge -> q=1100 after the edge; q was unchanged before the edge.
- Follow: keep en=1, change data to 0110, one edge -> q=0110. Then change data every cycle (0001, 0010, 0011) -> q tracks each value with exactly one cycle of delay.
- Hold after load: en=0, data=1111 for several edges -> q remains 0110.
- Asynchronous reset mid-operation: with q=0110 and en=1, assert reset=1 between clk edges -> q=0000 before the next edge. q stays 0000 across edges while reset=1, even with en=1 and data=1111. After reset=0 with en=1, data=0101, the first edge gives q=0101.
